// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the IFU/LSU memory arbiter.
// Round-robin grant is selected with MEM_ARB_RR_EN (fixed LSU priority otherwise).
package mem_arb_pkg;

  localparam int DEF_ADDR_W = 64;
  localparam int DEF_DATA_W = 64;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  typedef enum logic {
    OWN_IFU = 1'b0,
    OWN_LSU = 1'b1
  } owner_t;

endpackage

// File: rtl/mem_arb_grant.sv
// Combinational grant between IFU and LSU requests.
// MEM_ARB_RR_EN: on contention grant the requester that did not win last time.
module mem_arb_grant
  import mem_arb_pkg::*;
(
  input  logic   ifu_valid,
  input  logic   lsu_valid,
`ifdef MEM_ARB_RR_EN
  input  owner_t last_owner,
`endif
  output logic   grant_ifu,
  output logic   grant_lsu
);

  always_comb begin
    grant_ifu = 1'b0;
    grant_lsu = 1'b0;
    if (ifu_valid && lsu_valid) begin
`ifdef MEM_ARB_RR_EN
      grant_ifu = (last_owner == OWN_LSU);
      grant_lsu = (last_owner == OWN_IFU);
`else
      grant_lsu = 1'b1;
`endif
    end else begin
      grant_ifu = ifu_valid;
      grant_lsu = lsu_valid;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between IFU fetch and LSU load/store, one transaction in flight.
// Define MEM_ARB_RR_EN for round-robin grant; default is fixed LSU priority.
//
// state   | meaning
// IDLE    | no transaction; grant one requester and latch its payload
// REQ     | mem_req_valid held with latched payload until mem_req_ready
// WAIT    | waiting for mem_resp_valid, then pulse owner's resp_valid
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int MASK_W = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ifu_req_valid,
  output logic              ifu_req_ready,
  input  logic [ADDR_W-1:0] ifu_req_addr,
  output logic              ifu_resp_valid,
  output logic [DATA_W-1:0] ifu_resp_data,
  input  logic              lsu_req_valid,
  output logic              lsu_req_ready,
  input  logic [ADDR_W-1:0] lsu_req_addr,
  input  logic              lsu_req_wen,
  input  logic [DATA_W-1:0] lsu_req_wdata,
  input  logic [MASK_W-1:0] lsu_req_wmask,
  output logic              lsu_resp_valid,
  output logic [DATA_W-1:0] lsu_resp_data,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic              mem_req_wen,
  output logic [DATA_W-1:0] mem_req_wdata,
  output logic [MASK_W-1:0] mem_req_wmask,
  input  logic              mem_resp_valid,
  input  logic [DATA_W-1:0] mem_resp_data
);

  state_t              state_q, state_d;
  owner_t              owner_q, owner_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                wen_q, wen_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [MASK_W-1:0]   wmask_q, wmask_d;
  logic                ifu_resp_valid_q, ifu_resp_valid_d;
  logic                lsu_resp_valid_q, lsu_resp_valid_d;
  logic [DATA_W-1:0]   ifu_resp_data_q, ifu_resp_data_d;
  logic [DATA_W-1:0]   lsu_resp_data_q, lsu_resp_data_d;
  logic                grant_ifu, grant_lsu;
`ifdef MEM_ARB_RR_EN
  owner_t              last_owner_q, last_owner_d;
`endif

  mem_arb_grant u_grant (
    .ifu_valid  (ifu_req_valid),
    .lsu_valid  (lsu_req_valid),
`ifdef MEM_ARB_RR_EN
    .last_owner (last_owner_q),
`endif
    .grant_ifu  (grant_ifu),
    .grant_lsu  (grant_lsu)
  );

  always_comb begin
    state_d          = state_q;
    owner_d          = owner_q;
    addr_d           = addr_q;
    wen_d            = wen_q;
    wdata_d          = wdata_q;
    wmask_d          = wmask_q;
    ifu_resp_valid_d = 1'b0;
    lsu_resp_valid_d = 1'b0;
    ifu_resp_data_d  = ifu_resp_data_q;
    lsu_resp_data_d  = lsu_resp_data_q;
`ifdef MEM_ARB_RR_EN
    last_owner_d     = last_owner_q;
`endif
    ifu_req_ready    = 1'b0;
    lsu_req_ready    = 1'b0;
    mem_req_valid    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        // Readies are held low while reset is asserted so no handshake can be seen.
        ifu_req_ready = grant_ifu & rst;
        lsu_req_ready = grant_lsu & rst;
        if (grant_lsu) begin
          addr_d  = lsu_req_addr;
          wen_d   = lsu_req_wen;
          wdata_d = lsu_req_wdata;
          wmask_d = lsu_req_wmask;
          owner_d = OWN_LSU;
          state_d = ST_REQ;
`ifdef MEM_ARB_RR_EN
          last_owner_d = OWN_LSU;
`endif
        end else if (grant_ifu) begin
          addr_d  = ifu_req_addr;
          wen_d   = 1'b0;
          wdata_d = '0;
          wmask_d = '0;
          owner_d = OWN_IFU;
          state_d = ST_REQ;
`ifdef MEM_ARB_RR_EN
          last_owner_d = OWN_IFU;
`endif
        end
      end
      ST_REQ: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (mem_resp_valid) begin
          if (owner_q == OWN_LSU) begin
            lsu_resp_data_d  = mem_resp_data;
            lsu_resp_valid_d = 1'b1;
          end else begin
            ifu_resp_data_d  = mem_resp_data;
            ifu_resp_valid_d = 1'b1;
          end
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q          <= ST_IDLE;
      owner_q          <= OWN_LSU;
      addr_q           <= '0;
      wen_q            <= 1'b0;
      wdata_q          <= '0;
      wmask_q          <= '0;
      ifu_resp_valid_q <= 1'b0;
      lsu_resp_valid_q <= 1'b0;
      ifu_resp_data_q  <= '0;
      lsu_resp_data_q  <= '0;
`ifdef MEM_ARB_RR_EN
      last_owner_q     <= OWN_LSU;
`endif
    end else begin
      state_q          <= state_d;
      owner_q          <= owner_d;
      addr_q           <= addr_d;
      wen_q            <= wen_d;
      wdata_q          <= wdata_d;
      wmask_q          <= wmask_d;
      ifu_resp_valid_q <= ifu_resp_valid_d;
      lsu_resp_valid_q <= lsu_resp_valid_d;
      ifu_resp_data_q  <= ifu_resp_data_d;
      lsu_resp_data_q  <= lsu_resp_data_d;
`ifdef MEM_ARB_RR_EN
      last_owner_q     <= last_owner_d;
`endif
    end
  end

  assign mem_req_addr   = addr_q;
  assign mem_req_wen    = wen_q;
  assign mem_req_wdata  = wdata_q;
  assign mem_req_wmask  = wmask_q;
  assign ifu_resp_valid = ifu_resp_valid_q;
  assign lsu_resp_valid = lsu_resp_valid_q;
  assign ifu_resp_data  = ifu_resp_data_q;
  assign lsu_resp_data  = lsu_resp_data_q;

endmodule
